// File: rtl/divider_pkg.sv
// Shared constants and the per-channel configuration record for the tick divider.
package divider_pkg;

  // Counter/divisor width and the divisor every channel starts with out of reset.
  localparam int CNT_W_DEFAULT   = 8;
  localparam int DEFAULT_DIV_VAL = 7;

  // One configuration write as seen by a single channel.
  // The div field is CNT_W_DEFAULT wide, so a top-level CNT_W must not exceed it.
  typedef struct packed {
    logic [CNT_W_DEFAULT-1:0] div;
    logic                     casc;
  } ch_cfg_t;

endpackage

// File: rtl/tick_div_channel.sv
// One divider channel: a counter with active/shadow divisors, an optional cascade
// gate from the upstream channel, and registered tick/square outputs.
module tick_div_channel
  import divider_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = DEFAULT_DIV_VAL
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    en,
  input  logic    casc_in,
  input  logic    sync,
  input  logic    wr,
  input  ch_cfg_t cfg,
  output logic    wrap,
  output logic    tick,
  output logic    sq
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] div_shd;
  logic             casc;
  logic [CNT_W-1:0] new_div;
  logic [CNT_W-1:0] eff_div;
  logic [CNT_W:0]   half_div;
  logic             adv;
  logic             sq_next;

  // Advance/wrap decode; divisors 0 and 1 both behave as divide-by-one, and the
  // square wave is high for the first ceil(eff_div/2) counts of each period.
  always_comb begin
    new_div  = CNT_W'(cfg.div);
    eff_div  = (div_act <= CNT_W'(1)) ? CNT_W'(1) : div_act;
    adv      = en & (~casc | casc_in);
    wrap     = adv & (cnt == (eff_div - CNT_W'(1)));
    half_div = ({1'b0, eff_div} + (CNT_W+1)'(1)) >> 1;
    sq_next  = ({1'b0, cnt} < half_div);
  end

  // Counter, divisor registers and output registers; sync beats a wrap, a wrap
  // beats the disabled-channel immediate load, and the shadow always takes a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      div_act <= CNT_W'(DEFAULT_DIV);
      div_shd <= CNT_W'(DEFAULT_DIV);
      casc    <= 1'b0;
      tick    <= 1'b0;
      sq      <= 1'b0;
    end else begin
      tick <= wrap & ~sync;
      if (en) begin
        sq <= sq_next;
      end
      if (wr) begin
        div_shd <= new_div;
        casc    <= cfg.casc;
      end
      if (sync) begin
        cnt     <= '0;
        div_act <= div_shd;
      end else if (wrap) begin
        cnt     <= '0;
        div_act <= wr ? new_div : div_shd;
      end else if (wr && !en) begin
        cnt     <= '0;
        div_act <= new_div;
      end else if (adv) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/prog_tick_divider.sv
// Multi-channel programmable tick divider: write decode, cascade wiring and one
// tick_div_channel per channel, all in the single system clock domain.
module prog_tick_divider
  import divider_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = DEFAULT_DIV_VAL
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_we,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]        cfg_div,
  input  logic                    cfg_casc,
  input  logic [N_CH-1:0]         ch_en,
  input  logic                    sync,
  output logic [N_CH-1:0]         tick,
  output logic [N_CH-1:0]         sq
);

  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0] wrap_w;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic    wr_sel;
    logic    casc_up;
    ch_cfg_t cfg_pkt;

    // Select this channel for a write and pick its upstream wrap; channel 0 has
    // no upstream, so its cascade input and cascade bit are held at zero.
    always_comb begin
      wr_sel       = cfg_we && (cfg_ch == CH_W'(gi));
      cfg_pkt.div  = CNT_W_DEFAULT'(cfg_div);
      cfg_pkt.casc = (gi == 0) ? 1'b0 : cfg_casc;
      casc_up      = (gi == 0) ? 1'b0 : wrap_w[(gi == 0) ? 0 : gi-1];
    end

    tick_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .en      (ch_en[gi]),
      .casc_in (casc_up),
      .sync    (sync),
      .wr      (wr_sel),
      .cfg     (cfg_pkt),
      .wrap    (wrap_w[gi]),
      .tick    (tick[gi]),
      .sq      (sq[gi])
    );
  end

endmodule
